card_corner_finder: RTL and testbench
=====================================

// Module: card_corner_finder
// PURPOSE
//  Finds the bounding edges of a thresholded card image by scanning outward from its
//  centre of mass. Sits after threshold/center_of_mass in the card-recognition pipeline.
//  Reads the thresholded frame buffer (single-port, 1-cycle read latency). Reports the
//  last foreground column/row in each of the four directions.
// PARAMETERS
//  HEIGHT  320  frame rows (y range 0..HEIGHT-1)
//  WIDTH   240  frame columns (x range 0..WIDTH-1); row-major address = y*WIDTH + x
// PORTS
//  clk_in             in   1   system clock
//  rst_in             in   1   asynchronous, active-low reset
//  find_corners_flag  in   1   start pulse; samples x_center/y_center
//  x_center           in   8   centre-of-mass column
//  y_center           in   9   centre-of-mass row
//  pixel_data_in      in   16  frame-buffer data for addr_out issued one cycle earlier
//  addr_out           out  17  frame-buffer read address
//  data_valid_out     out  1   one-cycle pulse: all four edges updated
//  right_edge         out  8   last foreground x at or right of centre, on row y_center
//  left_edge          out  8   last foreground x at or left of centre, on row y_center
//  top_edge           out  9   last foreground y at or above centre, on column x_center
//  bot_edge           out  9   last foreground y at or below centre, on column x_center
// BEHAVIOUR
//  - Reset (rst_in=0, async): FSM->IDLE; addr_out, data_valid_out and all edges = 0.
//  - Foreground pixel: pixel_data_in != 16'h0000; background: == 0.
//  - IDLE: on find_corners_flag=1 latch centre (clamp x to WIDTH-1, y to HEIGHT-1),
//    go SCAN_RIGHT. Flag while not IDLE is ignored.
//  - Each probe takes 2 cycles: cycle A drive addr_out = y*WIDTH+x; cycle B compare
//    pixel_data_in. Foreground -> record coord as candidate edge, step; background or
//    frame border reached -> finalise edge as last foreground coord, next state.
//  - Order: SCAN_RIGHT (x+1..WIDTH-1), SCAN_LEFT (x-1..0), SCAN_DOWN -> bot_edge
//    (y+1..HEIGHT-1), SCAN_UP -> top_edge (y-1..0), then DONE.
//  - First probe of every direction is the centre pixel itself; if centre is
//    background, that edge = centre coordinate and the scan stops immediately.
//  - Border: at x=WIDTH-1 / 0 or y=HEIGHT-1 / 0 with foreground, edge = border; no wrap,
//    no out-of-range address ever issued (addr_out < WIDTH*HEIGHT always).
//  - DONE: update all four edge outputs simultaneously, data_valid_out=1 for exactly one
//    cycle, return to IDLE. Edge outputs hold until next DONE or reset.
//  - Latency from flag to data_valid_out <= 2*(WIDTH+HEIGHT+4)+2 cycles.
//  - Address math: 17-bit unsigned; y*WIDTH computed with constant multiply.
//  - Reset mid-scan: abort, outputs to reset values; next flag starts fresh.
// STRUCTURE
//  - Shared package: state enum (IDLE, SCAN_RIGHT, SCAN_LEFT, SCAN_DOWN, SCAN_UP, DONE),
//    frame WIDTH/HEIGHT constants, FG/BG pixel constants.
//  - Single flat module; no sub-module needed (one FSM + probe counter + address calc).
// TESTING
//  - Behavioural RAM (1-cycle latency) with foreground rect x40..199,y60..259; flag with
//    centre (120,160) -> right=199 left=40 top=60 bot=259, one data_valid_out pulse.
//  - All-foreground frame, centre (10,300) -> right=239 left=0 top=0 bot=319, no
//    addr_out >= 76800 at any cycle.
//  - Centre pixel background, centre (5,7) -> right=left=5, top=bot=7, valid pulse.
//  - Second flag pulse during SCAN_LEFT -> ignored; exactly one valid pulse, results
//    identical to first scenario.
//  - Assert rst_in low mid SCAN_DOWN -> outputs 0 immediately; release, new flag ->
//    correct edges from first scenario.
//  - Every run: cycles flag->valid within the latency bound above.

Source files
------------

// File: rtl/card_corner_finder_pkg.sv
// Shared definitions for the card corner finder: frame geometry, pixel
// classification constants and the scan state encoding.
package card_corner_finder_pkg;

  localparam int FRAME_WIDTH  = 240;
  localparam int FRAME_HEIGHT = 320;

  localparam int X_W    = 8;
  localparam int Y_W    = 9;
  localparam int ADDR_W = 17;
  localparam int PIX_W  = 16;

  localparam logic [PIX_W-1:0] PIX_BG = 16'h0000;
  localparam logic [PIX_W-1:0] PIX_FG = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SCAN_RIGHT = 3'd1,
    SCAN_LEFT  = 3'd2,
    SCAN_DOWN  = 3'd3,
    SCAN_UP    = 3'd4,
    DONE       = 3'd5
  } scan_state_t;

  // Any non-zero thresholded value counts as card (foreground).
  function automatic logic is_fg(input logic [PIX_W-1:0] pix);
    return (pix != PIX_BG);
  endfunction

endpackage

// File: rtl/card_corner_finder_if.sv
// Bundle of the corner finder's request, frame-buffer and result signals.
// master = the pipeline/frame-buffer side, slave = the corner finder.
interface card_corner_finder_if;
  import card_corner_finder_pkg::*;

  logic              find_corners_flag;
  logic [X_W-1:0]    x_center;
  logic [Y_W-1:0]    y_center;
  logic [PIX_W-1:0]  pixel_data_in;
  logic [ADDR_W-1:0] addr_out;
  logic              data_valid_out;
  logic [X_W-1:0]    right_edge;
  logic [X_W-1:0]    left_edge;
  logic [Y_W-1:0]    top_edge;
  logic [Y_W-1:0]    bot_edge;

  modport master (
    output find_corners_flag, x_center, y_center, pixel_data_in,
    input  addr_out, data_valid_out, right_edge, left_edge, top_edge, bot_edge
  );

  modport slave (
    input  find_corners_flag, x_center, y_center, pixel_data_in,
    output addr_out, data_valid_out, right_edge, left_edge, top_edge, bot_edge
  );
endinterface

// File: rtl/card_corner_finder.sv
// Card corner finder: from the latched centre of mass, probes the frame buffer
// outward right, left, down and up, keeping the last foreground coordinate in
// each direction. Each probe is two cycles (address out, then compare data).
module card_corner_finder
  import card_corner_finder_pkg::*;
#(
  parameter int WIDTH  = FRAME_WIDTH,
  parameter int HEIGHT = FRAME_HEIGHT
) (
  input  logic               clk_in,
  input  logic               rst_in,
  card_corner_finder_if.slave bus
);

  localparam logic [X_W-1:0] X_MAX = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(HEIGHT - 1);

  // Row-major frame address; coordinates are always kept inside the frame.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
  endfunction

  scan_state_t       state;
  logic              phase;     // 0: address presented, 1: data ready to compare
  logic [X_W-1:0]    cx, px;
  logic [Y_W-1:0]    cy, py;
  logic [X_W-1:0]    right_c, left_c;
  logic [Y_W-1:0]    top_c, bot_c;
  logic [ADDR_W-1:0] addr;
  logic              valid;
  logic [X_W-1:0]    right_q, left_q;
  logic [Y_W-1:0]    top_q, bot_q;
  logic              fg;
  logic [X_W-1:0]    x_clamp;
  logic [Y_W-1:0]    y_clamp;

  assign fg      = is_fg(bus.pixel_data_in);
  assign x_clamp = (bus.x_center > X_MAX) ? X_MAX : bus.x_center;
  assign y_clamp = (bus.y_center > Y_MAX) ? Y_MAX : bus.y_center;

  assign bus.addr_out       = addr;
  assign bus.data_valid_out = valid;
  assign bus.right_edge     = right_q;
  assign bus.left_edge      = left_q;
  assign bus.top_edge       = top_q;
  assign bus.bot_edge       = bot_q;

  // Scan sequencer: probe stepping, candidate edge tracking and result publication.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state   <= IDLE;
      phase   <= 1'b0;
      cx      <= '0;
      cy      <= '0;
      px      <= '0;
      py      <= '0;
      right_c <= '0;
      left_c  <= '0;
      top_c   <= '0;
      bot_c   <= '0;
      addr    <= '0;
      valid   <= 1'b0;
      right_q <= '0;
      left_q  <= '0;
      top_q   <= '0;
      bot_q   <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.find_corners_flag) begin
            cx      <= x_clamp;
            cy      <= y_clamp;
            px      <= x_clamp;
            py      <= y_clamp;
            right_c <= x_clamp;
            left_c  <= x_clamp;
            top_c   <= y_clamp;
            bot_c   <= y_clamp;
            addr    <= pix_addr(x_clamp, y_clamp);
            phase   <= 1'b0;
            state   <= SCAN_RIGHT;
          end
        end
        SCAN_RIGHT: begin
          phase <= ~phase;
          if (phase) begin
            if (fg) right_c <= px;
            if (fg && (px != X_MAX)) begin
              px   <= px + 8'd1;
              addr <= pix_addr(px + 8'd1, cy);
            end else begin
              px    <= cx;
              addr  <= pix_addr(cx, cy);
              state <= SCAN_LEFT;
            end
          end
        end
        SCAN_LEFT: begin
          phase <= ~phase;
          if (phase) begin
            if (fg) left_c <= px;
            if (fg && (px != 8'd0)) begin
              px   <= px - 8'd1;
              addr <= pix_addr(px - 8'd1, cy);
            end else begin
              py    <= cy;
              addr  <= pix_addr(cx, cy);
              state <= SCAN_DOWN;
            end
          end
        end
        SCAN_DOWN: begin
          phase <= ~phase;
          if (phase) begin
            if (fg) bot_c <= py;
            if (fg && (py != Y_MAX)) begin
              py   <= py + 9'd1;
              addr <= pix_addr(cx, py + 9'd1);
            end else begin
              py    <= cy;
              addr  <= pix_addr(cx, cy);
              state <= SCAN_UP;
            end
          end
        end
        SCAN_UP: begin
          phase <= ~phase;
          if (phase) begin
            if (fg) top_c <= py;
            if (fg && (py != 9'd0)) begin
              py   <= py - 9'd1;
              addr <= pix_addr(cx, py - 9'd1);
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          right_q <= right_c;
          left_q  <= left_c;
          top_q   <= top_c;
          bot_q   <= bot_c;
          valid   <= 1'b1;
          phase   <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          phase <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_card_corner_finder.sv
// Self-checking bench for card_corner_finder: behavioural 1-cycle frame RAM,
// directed scenarios plus randomized frames checked against a loop-based model.
module tb_card_corner_finder;
  import card_corner_finder_pkg::*;

  localparam int W       = FRAME_WIDTH;
  localparam int H       = FRAME_HEIGHT;
  localparam int NPIX    = W * H;
  localparam int BOUND   = 2 * (W + H + 4) + 2;
  localparam int LIMIT   = BOUND + 50;

  logic clk;
  logic rst_n;
  card_corner_finder_if bus ();

  card_corner_finder dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  logic [15:0] img [H][W];
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int oob    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame buffer: data for the address seen at this edge appears after it.
  always @(posedge clk) begin
    if (int'(bus.addr_out) < NPIX)
      bus.pixel_data_in <= img[int'(bus.addr_out) / W][int'(bus.addr_out) % W];
    else
      bus.pixel_data_in <= 16'h0000;
  end

  // Monitors: valid pulses and out-of-range addresses.
  always @(negedge clk) begin
    if (bus.data_valid_out === 1'b1) pulses++;
    if (rst_n && (int'(bus.addr_out) >= NPIX)) oob++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Blank frame plus a filled rectangle and optional random speckle.
  task automatic make_frame(input int x0, input int x1, input int y0, input int y1,
                            input int noise);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = (x >= x0 && x <= x1 && y >= y0 && y <= y1)
                    ? 16'($urandom_range(1, 65535)) : 16'h0000;
    for (int n = 0; n < noise; n++)
      img[$urandom_range(0, H-1)][$urandom_range(0, W-1)] =
        ($urandom_range(0, 1) == 1) ? 16'($urandom_range(1, 65535)) : 16'h0000;
  endtask

  // Reference: walk outward from the clamped centre while pixels stay non-zero.
  task automatic model(input int xc, input int yc,
                       output int r, output int l, output int t, output int b);
    int cx, cy;
    cx = (xc > W-1) ? W-1 : xc;
    cy = (yc > H-1) ? H-1 : yc;
    r = cx; l = cx; t = cy; b = cy;
    if (img[cy][cx] != 16'h0000) begin
      while (r < W-1 && img[cy][r+1] != 16'h0000) r++;
      while (l > 0   && img[cy][l-1] != 16'h0000) l--;
      while (b < H-1 && img[b+1][cx] != 16'h0000) b++;
      while (t > 0   && img[t-1][cx] != 16'h0000) t--;
    end
  endtask

  // One scan; optionally re-pulses the flag (other centre) at cycle dup_at.
  task automatic run_scan(input string tag, input int xc, input int yc,
                          input int dup_at, output int lat);
    @(negedge clk);
    pulses = 0;
    bus.x_center = 8'(xc);
    bus.y_center = 9'(yc);
    bus.find_corners_flag = 1'b1;
    @(negedge clk);
    bus.find_corners_flag = 1'b0;
    lat = 1;
    while (bus.data_valid_out !== 1'b1 && lat < LIMIT) begin
      if (lat == dup_at) begin
        bus.x_center = 8'd50;
        bus.y_center = 9'd70;
        bus.find_corners_flag = 1'b1;
      end else begin
        bus.find_corners_flag = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.find_corners_flag = 1'b0;
    check({tag, "_valid_seen"}, 32'(bus.data_valid_out), 32'd1);
    check({tag, "_latency_ok"}, 32'(lat <= BOUND), 32'd1);
  endtask

  task automatic expect_edges(input string tag, input int r, input int l,
                              input int t, input int b);
    check({tag, "_right"}, 32'(bus.right_edge), 32'(r));
    check({tag, "_left"},  32'(bus.left_edge),  32'(l));
    check({tag, "_top"},   32'(bus.top_edge),   32'(t));
    check({tag, "_bot"},   32'(bus.bot_edge),   32'(b));
  endtask

  task automatic expect_one_pulse(input string tag);
    repeat (6) @(negedge clk);
    check({tag, "_pulses"}, 32'(pulses), 32'd1);
  endtask

  initial begin
    int lat, r, l, t, b, xc, yc, x0, x1, y0, y1;
    rst_n = 1'b0;
    bus.find_corners_flag = 1'b0;
    bus.x_center = 8'd0;
    bus.y_center = 9'd0;
    make_frame(40, 199, 60, 259, 0);
    repeat (3) @(negedge clk);
    check("rst_addr",  32'(bus.addr_out), 32'd0);
    check("rst_valid", 32'(bus.data_valid_out), 32'd0);
    expect_edges("rst", 0, 0, 0, 0);
    rst_n = 1'b1;

    // Centred rectangle.
    run_scan("rect", 120, 160, -1, lat);
    expect_edges("rect", 199, 40, 60, 259);
    expect_one_pulse("rect");

    // Whole frame foreground: every scan hits the border.
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = PIX_FG;
    oob = 0;
    run_scan("full", 10, 300, -1, lat);
    expect_edges("full", 239, 0, 0, 319);
    expect_one_pulse("full");
    check("full_no_oob", 32'(oob), 32'd0);

    // Out-of-range centre is clamped to the frame corner.
    run_scan("clamp", 255, 511, -1, lat);
    expect_edges("clamp", 239, 0, 0, 319);
    check("clamp_no_oob", 32'(oob), 32'd0);

    // Background centre: every edge collapses onto the centre.
    make_frame(40, 199, 60, 259, 0);
    run_scan("bgctr", 5, 7, -1, lat);
    expect_edges("bgctr", 5, 5, 7, 7);
    expect_one_pulse("bgctr");

    // Extra flag during the left scan must be ignored.
    run_scan("dupflag", 120, 160, 200, lat);
    expect_edges("dupflag", 199, 40, 60, 259);
    expect_one_pulse("dupflag");

    // Reset during the downward scan, then a clean restart.
    @(negedge clk);
    bus.x_center = 8'd120;
    bus.y_center = 9'd160;
    bus.find_corners_flag = 1'b1;
    @(negedge clk);
    bus.find_corners_flag = 1'b0;
    repeat (400) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_addr",  32'(bus.addr_out), 32'd0);
    check("midrst_valid", 32'(bus.data_valid_out), 32'd0);
    expect_edges("midrst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_scan("afterrst", 120, 160, -1, lat);
    expect_edges("afterrst", 199, 40, 60, 259);
    expect_one_pulse("afterrst");

    // Randomized rectangles, speckle and centres (including out-of-range).
    for (int i = 0; i < 8; i++) begin
      x0 = $urandom_range(0, W-1); x1 = $urandom_range(x0, W-1);
      y0 = $urandom_range(0, H-1); y1 = $urandom_range(y0, H-1);
      make_frame(x0, x1, y0, y1, 300);
      if ($urandom_range(0, 3) == 0) begin
        xc = $urandom_range(0, 255); yc = $urandom_range(0, 511);
      end else begin
        xc = $urandom_range(x0, x1); yc = $urandom_range(y0, y1);
      end
      model(xc, yc, r, l, t, b);
      oob = 0;
      run_scan("rand", xc, yc, -1, lat);
      expect_edges("rand", r, l, t, b);
      expect_one_pulse("rand");
      check("rand_no_oob", 32'(oob), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
